// File: rtl/mm_round_ctrl_if.sv
// Player/generator/display signal bundle for the Memory Matrix round controller.
// The master side (player logic, generator, bench) drives requests; the controller is the slave.
interface mm_round_ctrl_if #(
    parameter int unsigned CELLS = 8,
    parameter int unsigned IDX_W = 3
);
    logic             start;
    logic             gen_req;
    logic             board_valid;
    logic [CELLS-1:0] board;
    logic             cell_valid;
    logic [IDX_W-1:0] cell_idx;
    logic [CELLS-1:0] disp;
    logic             hit;
    logic             miss;
    logic             round_done;
    logic             game_over;
    logic [7:0]       score;
    logic [3:0]       level;
    logic [1:0]       lives;

    modport master (
        output start, board_valid, board, cell_valid, cell_idx,
        input  gen_req, disp, hit, miss, round_done, game_over, score, level, lives
    );

    modport slave (
        input  start, board_valid, board, cell_valid, cell_idx,
        output gen_req, disp, hit, miss, round_done, game_over, score, level, lives
    );
endinterface

// File: rtl/mm_round_ctrl.sv
// Memory Matrix round sequencer: fetch a board, show it, score guesses, advance level or end game.
// gen_req and disp decode the registered state; every other output is a register.
module mm_round_ctrl #(
    parameter int unsigned CELLS       = 8,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned SHOW_CYCLES = 16,
    parameter int unsigned MAX_LIVES   = 3
) (
    input  logic            clk,
    input  logic            reset,
    mm_round_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam int unsigned IDX_XW = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_SHOW,
        S_PLAY,
        S_WIN,
        S_OVER
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CELLS-1:0] r_board;
    logic [CELLS-1:0] r_found;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_score;
    logic [3:0]       r_level;
    logic [1:0]       r_lives;
    logic             r_hit;
    logic             r_miss;
    logic             r_round_done;
    logic             r_game_over;

    logic             w_gen_req;
    logic [CELLS-1:0] w_disp;
    logic             w_start_game;
    logic             w_take_board;
    logic             w_idx_ok;
    logic             w_guess;
    logic [CELLS-1:0] w_bit;
    logic [CELLS-1:0] w_found_add;
    logic             w_new_hit;
    logic             w_wrong;

    // Guess qualification: indices past the board are dropped silently.
    assign w_start_game = bus.start && ((r_state == S_IDLE) || (r_state == S_OVER));
    assign w_take_board = (r_state == S_GEN) && bus.board_valid && (|bus.board);
    assign w_idx_ok     = ({1'b0, bus.cell_idx} < IDX_XW'(CELLS));
    assign w_guess      = (r_state == S_PLAY) && bus.cell_valid && w_idx_ok;
    assign w_bit        = CELLS'(1) << bus.cell_idx;
    assign w_found_add  = r_found | w_bit;
    assign w_new_hit    = w_guess && (|(r_board & w_bit)) && !(|(r_found & w_bit));
    assign w_wrong      = w_guess && !(|(r_board & w_bit));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_gen_req = 1'b0;
        w_disp    = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_GEN;
            end
            S_GEN: begin
                w_gen_req = 1'b1;
                if (w_take_board) w_next = S_SHOW;
            end
            S_SHOW: begin
                w_disp = r_board;
                if (r_cnt == '0) w_next = S_PLAY;
            end
            S_PLAY: begin
                w_disp = r_found;
                if (w_new_hit && (w_found_add == r_board)) begin
                    w_next = S_WIN;
                end else if (w_wrong && (r_lives == 2'd1)) begin
                    w_next = S_OVER;
                end
            end
            S_WIN: begin
                w_next = S_GEN;
            end
            S_OVER: begin
                if (bus.start) w_next = S_GEN;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Round/game bookkeeping and registered pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_board      <= '0;
            r_found      <= '0;
            r_cnt        <= '0;
            r_score      <= '0;
            r_level      <= '0;
            r_lives      <= 2'(MAX_LIVES);
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
            r_round_done <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_hit        <= w_new_hit;
            r_miss       <= w_wrong;
            r_round_done <= (w_next == S_WIN);
            r_game_over  <= (w_next == S_OVER);
            if (w_start_game) begin
                r_score <= '0;
                r_level <= '0;
                r_found <= '0;
                r_lives <= 2'(MAX_LIVES);
            end
            if (w_take_board) begin
                r_board <= bus.board;
                r_found <= '0;
                r_cnt   <= CNT_W'(SHOW_CYCLES - 1);
            end
            if ((r_state == S_SHOW) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_new_hit) begin
                r_found <= w_found_add;
                if (r_score != 8'hFF) r_score <= r_score + 8'd1;
            end
            if (w_wrong) begin
                r_lives <= r_lives - 2'd1;
            end
            if ((r_state == S_WIN) && (r_level != 4'hF)) begin
                r_level <= r_level + 4'd1;
            end
        end
    end

    assign bus.gen_req    = w_gen_req;
    assign bus.disp       = w_disp;
    assign bus.hit        = r_hit;
    assign bus.miss       = r_miss;
    assign bus.round_done = r_round_done;
    assign bus.game_over  = r_game_over;
    assign bus.score      = r_score;
    assign bus.level      = r_level;
    assign bus.lives      = r_lives;
endmodule

// File: doc/mm_round_ctrl.md
Name: mm_round_ctrl

Overview:
- Game-sequencing controller for the Memory Matrix board datapath.
- Each round it:
  - requests a pseudo-random board from the board generator;
  - shows the board for a fixed time, then hides it;
  - takes the player's cell guesses and scores them against the latched board;
  - advances the level, or ends the game.
- Sits between the player input logic (keys/switches) and the display driver.

Parameters:
- CELLS, 8, number of board cells; equals board width.
- IDX_W, 3, width of cell index; CELLS <= 2**IDX_W.
- SHOW_CYCLES, 16, number of clk cycles the board is displayed per round. Must be ≥ 1.
- MAX_LIVES, 3, lives at game start. Range 1..3.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low; clock clk
- start  in  1  level; start a new game from IDLE or OVER
- gen_req  out  1  board request to generator; held high in GEN until board_valid
- board_valid  in  1  generator board valid; sampled only in GEN
- board  in  CELLS  generated board; bit i = 1 marks cell i as lit
- cell_valid  in  1  one-cycle guess strobe
- cell_idx  in  IDX_W  guessed cell
- disp  out  CELLS  cells to light: latched board in SHOW, found mask in PLAY, 0 otherwise
- hit  out  1  one-cycle pulse: new correct cell
- miss  out  1  one-cycle pulse: wrong cell
- round_done  out  1  high for exactly one cycle, in WIN
- game_over  out  1  high while in OVER
- score  out  8  total correct cells; saturates at 255
- level  out  4  rounds completed; saturates at 15
- lives  out  2  remaining lives

Behaviour:
- States: IDLE, GEN, SHOW, PLAY, WIN, OVER. All outputs and state are registered, except disp and gen_req, which decode registered state only.
- Reset (reset = 0 at a clk edge) from any state, including mid-round:
  - state = IDLE;
  - score, level, found mask and latched board = 0;
  - lives = MAX_LIVES;
  - hit, miss, round_done = 0.
- IDLE:
  - start = 1 → GEN; score, level and found mask are cleared and lives = MAX_LIVES on that edge.
- GEN:
  - gen_req = 1.
  - When board_valid = 1 and board ≠ 0: latch board, clear found mask, load show counter with SHOW_CYCLES−1, go to SHOW.
  - When board_valid = 1 and board = 0: discard it, stay in GEN, gen_req stays high.
- SHOW:
  - disp = latched board for exactly SHOW_CYCLES cycles; counter decrements each cycle.
  - Counter = 0 → PLAY.
  - cell_valid is ignored.
- PLAY: disp = found mask. On cell_valid = 1, with i = cell_idx:
  - i ≥ CELLS: ignored, no pulse.
  - board[i] = 1 and found[i] = 0: set found[i]; score += 1 (saturating); hit = 1 next cycle. If found now equals board → WIN.
  - board[i] = 1 and found[i] = 1: repeat guess, ignored, no pulse, no penalty.
  - board[i] = 0: miss = 1 next cycle; lives −= 1. If lives was 1 → OVER (lives = 0).
- Guess latency: the update is applied at the edge that samples cell_valid, and the hit/miss pulse is visible in the following cycle. At most one guess is accepted per cycle.
- WIN:
  - round_done = 1 for one cycle; level += 1 (saturating at 15) on exit.
  - Then → GEN automatically.
  - Lives are not restored between rounds.
- OVER:
  - game_over = 1; disp = 0.
  - score and level hold.
  - start = 1 → GEN, with the same clearing as from IDLE.
- start is ignored in GEN, SHOW, PLAY and WIN. cell_valid is ignored outside PLAY.
- board is sampled only on the accepting edge in GEN; later changes on board have no effect until the next GEN.

Test Plan:
- Reset, start = 1, generator returns board = 8'hA5 on the 3rd GEN cycle → gen_req high for 3 cycles; disp = A5 for exactly 16 cycles; then PLAY with disp = 0.
- In PLAY with board A5, guess 0, 2, 5, 7 → four hit pulses; score = 4; disp builds 01, 05, 25, A5; round_done for one cycle; level = 1; gen_req high the next cycle.
- Board A5, guess 1, then 0, then 0 again → miss and lives = 2; hit and score = 1; third guess gives no pulse, score stays 1.
- Three wrong guesses (1, 3, 4) → lives 2, 1, 0; game_over = 1 after the third; further cell_valid has no effect; start → GEN with lives = 3, score = 0.
- In GEN, board_valid with board = 0, then a second board_valid with board = 8'h10 → first is ignored with gen_req still high; the second is latched and SHOW begins.
- reset = 0 in the middle of SHOW, and again in PLAY with score = 2 → next cycle IDLE, disp = 0, score = 0, lives = 3, level = 0.
